// File: rtl/dmem_controller.sv
// Multi-cycle controller and two-port arbiter for the single-port data memory.
// Port A is the pipeline MEM stage and port B is the debug/loader port. A
// bounded-starvation counter forces a port B grant after STARVE_MAX
// consecutive port A grants made while port B was waiting.
module dmem_controller #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // Port A: pipeline MEM stage
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic [31:0] RDM,
  // Port B: debug / loader
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  // Memory side
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CntW-1:0]    CntLast   = CntW'(LATENCY - 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

  typedef enum logic [2:0] {StIdle, StAccA, StAccB, StDoneA, StDoneB} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [CntW-1:0]     r_cnt;
  logic [StarveW-1:0]  r_starve;
  logic                w_grant_a;
  logic                w_grant_b;
  logic                w_last;
  logic                w_in_acc;

  logic                r_mem_en;
  logic                r_mem_we;
  logic [31:0]         r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic [31:0]         r_rdm;
  logic [31:0]         r_dbg_rdata;

  assign w_last   = (r_cnt == CntLast);
  assign w_in_acc = (r_state == StAccA) || (r_state == StAccB);

  // Arbitration (IDLE only) and next-state selection.
  always_comb begin
    w_state_next = r_state;
    w_grant_a    = 1'b0;
    w_grant_b    = 1'b0;
    case (r_state)
      StIdle: begin
        if (MemReqM && dbg_req) begin
          if (r_starve >= StarveMax) w_grant_b = 1'b1;
          else                       w_grant_a = 1'b1;
        end else if (MemReqM) begin
          w_grant_a = 1'b1;
        end else if (dbg_req) begin
          w_grant_b = 1'b1;
        end
        if (w_grant_a)      w_state_next = StAccA;
        else if (w_grant_b) w_state_next = StAccB;
      end
      StAccA:  if (w_last) w_state_next = StDoneA;
      StAccB:  if (w_last) w_state_next = StDoneB;
      StDoneA: w_state_next = StIdle;
      StDoneB: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // State register and access-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_in_acc && !w_last) r_cnt <= r_cnt + 1'b1;
      else                     r_cnt <= '0;
    end
  end

  // Starvation counter: counts A grants that bypassed a waiting port B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_grant_a && dbg_req) begin
      if (r_starve < StarveMax) r_starve <= r_starve + 1'b1;
    end else if (w_grant_b || ((r_state == StIdle) && !dbg_req)) begin
      r_starve <= '0;
    end
  end

  // Memory command launch on grant, read-data capture on the last access cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdm       <= '0;
      r_dbg_rdata <= '0;
    end else if (w_grant_a) begin
      r_mem_en    <= 1'b1;
      r_mem_we    <= MemWriteM;
      r_mem_addr  <= ALUOutM;
      r_mem_wdata <= WriteDataM;
    end else if (w_grant_b) begin
      r_mem_en    <= 1'b1;
      r_mem_we    <= dbg_we;
      r_mem_addr  <= dbg_addr;
      r_mem_wdata <= dbg_wdata;
    end else if (w_in_acc && w_last) begin
      // Address and write data are left as-is after the access.
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      if (!r_mem_we) begin
        if (r_state == StAccA) r_rdm       <= mem_rdata;
        else                   r_dbg_rdata <= mem_rdata;
      end
    end
  end

  assign StallM    = MemReqM && (r_state != StDoneA);
  assign dbg_ack   = (r_state == StDoneB);
  assign RDM       = r_rdm;
  assign dbg_rdata = r_dbg_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_controller.sv
// Self-checking bench for dmem_controller: directed vector table, multi-cycle
// corner sequences, and randomized two-port traffic against a word-array model.
module tb_dmem_controller;

  localparam int unsigned LAT  = 2;
  localparam int unsigned SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReqM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM, RDM;
  logic        StallM;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_controller #(.LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemReqM(MemReqM), .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .StallM(StallM), .RDM(RDM),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Physical memory: 256 words, combinational read, written by the DUT.
  logic [31:0] tb_mem [256];
  assign mem_rdata = tb_mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_en && mem_we) tb_mem[mem_addr[9:2]] <= mem_wdata;

  // Reference model: what each word must hold, at transaction level.
  logic [31:0] ref_mem [256];
  bit          ref_vld [256];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Port A access; called and returns at posedge+1.
  task automatic a_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output int stall_cyc, output int en_cyc,
                          output bit cmd_ok, output bit timeout);
    MemReqM = 1'b1; MemWriteM = we; ALUOutM = addr; WriteDataM = wdata;
    stall_cyc = 0; en_cyc = 0; cmd_ok = 1'b1; timeout = 1'b1; rd = '0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cyc++;
        if (mem_addr !== addr || mem_we !== we || (we && mem_wdata !== wdata)) cmd_ok = 1'b0;
      end
      if (StallM) stall_cyc++;
      else begin
        rd = RDM; timeout = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    MemReqM = 1'b0;
  endtask

  // Port B access; called and returns at posedge+1, dbg_req dropped after ack.
  task automatic b_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output int ack_cyc, output bit stall_seen,
                          output bit timeout);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    ack_cyc = -1; stall_seen = 1'b0; timeout = 1'b1; rd = '0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (StallM) stall_seen = 1'b1;
      if (dbg_ack) begin
        rd = dbg_rdata; ack_cyc = c; timeout = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    dbg_req = 1'b0;
  endtask

  typedef struct {
    bit          port_b;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;  // expected RDM / dbg_rdata afterwards (held value for stores)
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] rd;
  int          cyc_a, cyc_b;
  bit          ok, to, stl;
  bit          grants[$];
  bit          exp_grant [6];
  bit          exp_stall [8];
  bit          exp_en    [8];
  bit          exp_ack   [8];
  logic [31:0] exp_rdm, exp_dbg;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 32'h80, 32'hCAFEF00D, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h80, 32'h0,        32'hCAFEF00D};
    vecs[2] = '{1'b0, 1'b1, 32'h44, 32'h12345678, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h44, 32'h0,        32'h12345678};
    vecs[4] = '{1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[5] = '{1'b0, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF};
    vecs[6] = '{1'b0, 1'b1, 32'h48, 32'h00000001, 32'hDEADBEEF};
    vecs[7] = '{1'b1, 1'b0, 32'h44, 32'h0,        32'h12345678};
    exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_stall = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_en    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_ack   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state.
    rst_n = 1'b0; MemReqM = 1'b0; MemWriteM = 1'b0; ALUOutM = '0; WriteDataM = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    #1;
    check("reset mem_en", 32'(mem_en), 32'h0);
    check("reset RDM", RDM, 32'h0);
    check("reset dbg_ack", 32'(dbg_ack), 32'h0);
    check("reset StallM idle", 32'(StallM), 32'h0);
    MemReqM = 1'b1; #1;
    check("reset StallM follows MemReqM", 32'(StallM), 32'h1);
    MemReqM = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].port_b) begin
        b_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, cyc_b, stl, to);
        check($sformatf("vec%0d dbg_rdata", i), rd, vecs[i].exp_rd);
        check($sformatf("vec%0d ack cycle", i), 32'(cyc_b), 32'(LAT + 1));
        check($sformatf("vec%0d StallM during B", i), 32'(stl), 32'h0);
        @(negedge clk);
        check($sformatf("vec%0d ack one-shot", i), 32'(dbg_ack), 32'h0);
        @(posedge clk); #1;
      end else begin
        a_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, cyc_a, cyc_b, ok, to);
        check($sformatf("vec%0d RDM", i), rd, vecs[i].exp_rd);
        check($sformatf("vec%0d stall cycles", i), 32'(cyc_a), 32'(LAT + 1));
        check($sformatf("vec%0d mem_en cycles", i), 32'(cyc_b), 32'(LAT));
        check($sformatf("vec%0d mem command", i), 32'(ok), 32'h1);
      end
    end

    // Reset in the first ACC_A cycle.
    MemReqM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h44;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort mem_en before reset", 32'(mem_en), 32'h1);
    rst_n = 1'b0; #1;
    check("abort mem_en", 32'(mem_en), 32'h0);
    check("abort mem_we", 32'(mem_we), 32'h0);
    check("abort RDM", RDM, 32'h0);
    check("abort dbg_ack", 32'(dbg_ack), 32'h0);
    check("abort dbg_rdata", dbg_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset StallM", 32'(StallM), 32'h1);
    check("post-reset mem_en idle", 32'(mem_en), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post-reset mem_en rises", 32'(mem_en), 32'h1);
    to = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!StallM) begin to = 1'b0; break; end
    end
    check("post-reset load done", 32'(to), 32'h0);
    check("post-reset load RDM", RDM, 32'h12345678);
    @(posedge clk); #1;
    MemReqM = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Starvation: A always requesting, B held until acked.
    MemReqM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h44;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h80;
    begin
      bit prev_en = 1'b0;
      bit drop_b;
      int acks = 0;
      for (int c = 0; c < 200 && grants.size() < 6; c++) begin
        @(negedge clk);
        if (mem_en && !prev_en) grants.push_back(mem_addr == 32'h80);
        prev_en = mem_en;
        drop_b = dbg_ack;
        if (dbg_ack) acks++;
        @(posedge clk); #1;
        if (drop_b) dbg_req = 1'b0;
      end
      MemReqM = 1'b0; dbg_req = 1'b0;
      check("starve grant count", 32'(grants.size()), 32'd6);
      for (int g = 0; g < 6 && g < grants.size(); g++)
        check($sformatf("starve grant%0d is B", g), 32'(grants[g]), 32'(exp_grant[g]));
      check("starve ack count", 32'(acks), 32'd1);
      check("starve dbg_rdata", dbg_rdata, 32'hCAFEF00D);
    end
    repeat (LAT + 3) @(posedge clk); #1;

    // Collision: MEM request arrives during ACC_B cycle 1.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h80;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("collide c%0d StallM", c), 32'(StallM), 32'(exp_stall[c]));
      check($sformatf("collide c%0d mem_en", c), 32'(mem_en), 32'(exp_en[c]));
      check($sformatf("collide c%0d dbg_ack", c), 32'(dbg_ack), 32'(exp_ack[c]));
      if (c == 3) check("collide dbg_rdata", dbg_rdata, 32'hCAFEF00D);
      if (c == 7) check("collide RDM", RDM, 32'hDEADBEEF);
      @(posedge clk); #1;
      if (c == 0) begin MemReqM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h40; end
      if (c == 3) dbg_req = 1'b0;
      if (c == 7) MemReqM = 1'b0;
    end

    // Randomized concurrent traffic; A and B use disjoint halves of memory.
    exp_rdm = 32'hDEADBEEF;
    exp_dbg = 32'hCAFEF00D;
    fork
      begin : a_thread
        logic [31:0] ard, awd;
        int          ast, aen, idx;
        bit          aok, ato, awe;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          idx = $urandom_range(0, 127);
          awe = !ref_vld[idx] || ($urandom_range(0, 1) == 1);
          awd = $urandom;
          a_access(awe, 32'(idx * 4), awd, ard, ast, aen, aok, ato);
          check($sformatf("rand A%0d done", i), 32'(ato), 32'h0);
          check($sformatf("rand A%0d min stall", i), 32'(ast >= int'(LAT + 1)), 32'h1);
          if (awe) begin
            ref_mem[idx] = awd; ref_vld[idx] = 1'b1;
            check($sformatf("rand A%0d RDM held", i), ard, exp_rdm);
          end else begin
            exp_rdm = ref_mem[idx];
            check($sformatf("rand A%0d load", i), ard, exp_rdm);
          end
        end
      end
      begin : b_thread
        logic [31:0] brd, bwd;
        int          back, idx;
        bit          bst, bto, bwe;
        for (int j = 0; j < 20; j++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          idx = $urandom_range(128, 255);
          bwe = !ref_vld[idx] || ($urandom_range(0, 1) == 1);
          bwd = $urandom;
          b_access(bwe, 32'(idx * 4), bwd, brd, back, bst, bto);
          check($sformatf("rand B%0d done", j), 32'(bto), 32'h0);
          check($sformatf("rand B%0d wait bound", j),
                32'(back <= int'((SMAX + 2) * (LAT + 2))), 32'h1);
          if (bwe) begin
            ref_mem[idx] = bwd; ref_vld[idx] = 1'b1;
            check($sformatf("rand B%0d dbg_rdata held", j), brd, exp_dbg);
          end else begin
            exp_dbg = ref_mem[idx];
            check($sformatf("rand B%0d read", j), brd, exp_dbg);
          end
        end
      end
    join

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_controller.md
# dmem_controller

Multi-cycle controller and two-port arbiter for the single-port data memory. It sits beside the memory stage and sequences every load and store issued by the pipeline (port A). It also shares the same memory with the debug/loader port (port B), which fills and inspects memory at run time. Because memory access takes LATENCY cycles, the controller drives StallM to the hazard unit to freeze the pipeline while a MEM-stage access is outstanding. A bounded-starvation counter guarantees that port B makes forward progress.

## Interface
- LATENCY, 2, cycles the memory needs per access; valid range is 1 or more.
- STARVE_MAX, 4, consecutive port-A grants allowed while port B waits. A value of 0 gives port B priority.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- MemReqM  input  1  MEM stage wants access (MemToRegM | MemWriteM).
- MemWriteM  input  1  1 = store, 0 = load.
- ALUOutM  input  32  byte address, passed unchanged.
- WriteDataM  input  32  store data.
- StallM  output  1  freeze IF..MEM; goes to the hazard unit.
- RDM  output  32  load data for the MEM/WB register.
- dbg_req  input  1  port B request; held until acknowledged.
- dbg_we  input  1  port B write enable.
- dbg_addr  input  32  port B address.
- dbg_wdata  input  32  port B write data.
- dbg_ack  output  1  one-cycle completion pulse.
- dbg_rdata  output  32  port B read data.
- mem_en  output  1  memory access enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  32  memory address.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data; valid in the last cycle of an access.

## Operation
- FSM states: IDLE, ACC_A, ACC_B, DONE_A, DONE_B. Counter cnt runs from 0 to LATENCY-1.
- Arbitration happens only in IDLE:
  - Only MemReqM asserted: go to ACC_A.
  - Only dbg_req asserted: go to ACC_B.
  - Both asserted: go to ACC_B if starve_cnt ≥ STARVE_MAX, otherwise ACC_A.
- starve_cnt:
  - Increments, saturating, on each A grant made while dbg_req = 1.
  - Clears on a B grant, or in any IDLE cycle with dbg_req = 0.
  - Width is $clog2(STARVE_MAX+1), minimum 1.
- Entering ACC_x: mem_en/mem_we/mem_addr/mem_wdata are registered from the granted port. They are held stable for exactly LATENCY cycles.
- Last ACC cycle (cnt = LATENCY-1):
  - mem_rdata is captured into RDM (A loads) or dbg_rdata (B reads).
  - Stores leave RDM and dbg_rdata unchanged.
  - The FSM goes to DONE_x, and mem_en/mem_we drop to 0 on entry.
  - mem_addr and mem_wdata keep their last values.
- DONE_A: StallM = 0 and RDM is valid. The pipeline advances at this edge, then the FSM returns to IDLE with no re-arbitration.
- DONE_B: dbg_ack = 1 for one cycle, then the FSM returns to IDLE. The requester drops dbg_req on the edge where it samples dbg_ack = 1.
- StallM is combinational: MemReqM & (state ≠ DONE_A).
  - A MEM request that arrives during ACC_B or DONE_B stalls until its own access completes.
- Port B fields must stay stable while dbg_req = 1. Changes before dbg_ack give undefined results.
- There are no alignment or range checks; addresses pass through as full 32 bits.

## Timing
- Reset, asynchronous on rst_n = 0:
  - State returns to IDLE; cnt and starve_cnt clear.
  - mem_en, mem_we, mem_addr, mem_wdata, RDM, dbg_rdata and dbg_ack all go to 0.
  - StallM follows MemReqM.
  - An access aborted mid-flight is abandoned. The content of an interrupted store location is undefined.
- Port A access, with cycle 0 being the first IDLE cycle in which MemReqM = 1:
  - Cycles 1..LATENCY are ACC_A.
  - Cycle LATENCY+1 is DONE_A.
  - StallM is high for LATENCY+1 cycles.
- Port B access from IDLE: dbg_ack is high in cycle LATENCY+1.
- Back-to-back accesses: the minimum gap from DONE_x to the next mem_en is 1 cycle (IDLE).

## Test plan
- Reset mid-access: assert rst_n = 0 during ACC_A cycle 1 with mem_en = 1. Required: mem_en, mem_we, RDM, dbg_ack and dbg_rdata are 0 immediately. After release, MemReqM = 1 gives StallM = 1 and mem_en rises one cycle later.
- Load, LATENCY = 2: MemReqM = 1, MemWriteM = 0, ALUOutM = 0x00000040, mem_rdata = 0xDEADBEEF. Required: StallM high for cycles 0–2 and low in cycle 3 with RDM = 0xDEADBEEF. mem_en is high for exactly cycles 1–2 with mem_addr = 0x40.
- Store then load: store 0x12345678 to 0x44. Required: mem_we and mem_en high for 2 cycles with mem_wdata = 0x12345678 and RDM unchanged. A following load of 0x44 from the memory model returns 0x12345678.
- Debug alone: MemReqM = 0, dbg_req read of 0x80 (memory holds 0xCAFEF00D). Required: StallM stays 0 and dbg_ack pulses once in cycle 3 with dbg_rdata = 0xCAFEF00D.
- Starvation, STARVE_MAX = 4: MemReqM is re-asserted every cycle and dbg_req is held high. Required: four consecutive A accesses, then the fifth grant goes to B. starve_cnt returns to 0 and the next grant goes to A.
- Collision: MemReqM rises during ACC_B cycle 1. Required: StallM goes to 1 in that cycle. ACC_A starts in the IDLE cycle after DONE_B, and StallM falls in the following DONE_A.
